// File: rtl/contador_checker_if.sv
// Observation bundle between the up/down/load counter and its checker:
// the counter's control and output as seen by the checker, plus the checker's results.
interface contador_checker_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             enable;
    logic             key;
    logic             load;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] counter_in;
    logic             mismatch;
    logic             fail;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] check_count;
    logic [WIDTH-1:0] first_exp;
    logic [WIDTH-1:0] first_obs;
    logic [1:0]       state;

    modport master (
        output enable, key, load, entrada, counter_in,
        input  mismatch, fail, error_count, check_count,
        input  first_exp, first_obs, state
    );

    modport slave (
        input  enable, key, load, entrada, counter_in,
        output mismatch, fail, error_count, check_count,
        output first_exp, first_obs, state
    );
endinterface

// File: rtl/contador_checker.sv
// Cycle-accurate reference model of the up/down/load counter; flags and
// counts every rising edge where the observed counter diverges from it.
module contador_checker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter bit RESYNC = 1'b0
) (
    input  logic clock,
    input  logic reset,
    contador_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] model_q, model_d;
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] error_count_q, error_count_d;
    logic [CNT_W-1:0] check_count_q, check_count_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;
    logic [WIDTH-1:0] first_obs_q, first_obs_d;

    logic             cmp;
    logic             miss;
    logic [WIDTH-1:0] base;

    always_comb begin
        cmp  = (state_q == CHECK) && bus.enable;
        miss = cmp && (bus.counter_in != model_q);

        // After a miss the resyncing variant predicts from what the counter showed
        base = (RESYNC && miss) ? bus.counter_in : model_q;

        if (bus.load) begin
            model_d = bus.entrada;
        end else if (bus.key) begin
            model_d = base + WIDTH'(1);
        end else begin
            model_d = base - WIDTH'(1);
        end

        mismatch_d    = miss;
        fail_d        = fail_q | miss;
        first_exp_d   = first_exp_q;
        first_obs_d   = first_obs_q;
        check_count_d = check_count_q;
        error_count_d = error_count_q;

        if (cmp && (check_count_q != CNT_MAX)) begin
            check_count_d = check_count_q + CNT_W'(1);
        end
        if (miss && (error_count_q != CNT_MAX)) begin
            error_count_d = error_count_q + CNT_W'(1);
        end
        if (miss && !fail_q) begin
            first_exp_d = model_q;
            first_obs_d = bus.counter_in;
        end

        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = CHECK;
            CHECK:   if (error_count_d == CNT_MAX) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            model_q       <= '0;
            mismatch_q    <= 1'b0;
            fail_q        <= 1'b0;
            error_count_q <= '0;
            check_count_q <= '0;
            first_exp_q   <= '0;
            first_obs_q   <= '0;
        end else begin
            state_q       <= state_d;
            model_q       <= model_d;
            mismatch_q    <= mismatch_d;
            fail_q        <= fail_d;
            error_count_q <= error_count_d;
            check_count_q <= check_count_d;
            first_exp_q   <= first_exp_d;
            first_obs_q   <= first_obs_d;
        end
    end

    assign bus.mismatch    = mismatch_q;
    assign bus.fail        = fail_q;
    assign bus.error_count = error_count_q;
    assign bus.check_count = check_count_q;
    assign bus.first_exp   = first_exp_q;
    assign bus.first_obs   = first_obs_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_contador_checker.sv
// Directed bench: a behavioural counter on the falling edge feeds three
// checkers (free-running, resyncing, 2-bit counters) with shared stimulus.
module tb_contador_checker;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       key;
    logic       load;
    logic [7:0] entrada;
    logic [7:0] cnt;
    logic [7:0] off;
    int         n_run;
    int         n_fail;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference counter; off lets the bench skew what the checkers observe
    always @(negedge clock or negedge reset) begin
        if (!reset)    cnt <= 8'd0;
        else if (load) cnt <= entrada;
        else if (key)  cnt <= cnt + 8'd1;
        else           cnt <= cnt - 8'd1;
    end

    contador_checker_if #(.WIDTH(8), .CNT_W(16)) if0 ();
    contador_checker_if #(.WIDTH(8), .CNT_W(16)) if1 ();
    contador_checker_if #(.WIDTH(8), .CNT_W(2))  if2 ();

    assign if0.enable     = enable;
    assign if0.key        = key;
    assign if0.load       = load;
    assign if0.entrada    = entrada;
    assign if0.counter_in = cnt + off;
    assign if1.enable     = enable;
    assign if1.key        = key;
    assign if1.load       = load;
    assign if1.entrada    = entrada;
    assign if1.counter_in = cnt + off;
    assign if2.enable     = enable;
    assign if2.key        = key;
    assign if2.load       = load;
    assign if2.entrada    = entrada;
    assign if2.counter_in = cnt + off;

    contador_checker #(.WIDTH(8), .CNT_W(16), .RESYNC(1'b0)) u0 (
        .clock(clock), .reset(reset), .bus(if0.slave)
    );
    contador_checker #(.WIDTH(8), .CNT_W(16), .RESYNC(1'b1)) u1 (
        .clock(clock), .reset(reset), .bus(if1.slave)
    );
    contador_checker #(.WIDTH(8), .CNT_W(2), .RESYNC(1'b0)) u2 (
        .clock(clock), .reset(reset), .bus(if2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge; returns just after the following falling edge
    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    initial begin
        n_run   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        key     = 1'b1;
        load    = 1'b0;
        entrada = 8'd0;
        off     = 8'd0;
        #2 reset = 1'b0;
        #10;
        chk("rst_state",  32'(if0.state), 32'd0);
        chk("rst_fail",   32'(if0.fail), 32'd0);
        chk("rst_err",    32'(if0.error_count), 32'd0);
        chk("rst_chk",    32'(if0.check_count), 32'd0);
        chk("rst_mis",    32'(if0.mismatch), 32'd0);

        @(negedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) begin
                chk("idle_state", 32'(if0.state), 32'd1);
                chk("idle_nochk", 32'(if0.check_count), 32'd0);
            end else begin
                chk("up_mis", 32'(if0.mismatch), 32'd0);
            end
        end
        chk("up_chk",   32'(if0.check_count), 32'd5);
        chk("up_fail",  32'(if0.fail), 32'd0);
        chk("up_state", 32'(if0.state), 32'd1);
        chk("sat_chk",  32'(if2.check_count), 32'd3);

        load = 1'b1; entrada = 8'hFE;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        key = 1'b0;
        cyc();
        key = 1'b1;
        cyc();
        chk("wrap_mis", 32'(if0.mismatch), 32'd0);
        chk("wrap_err", 32'(if0.error_count), 32'd0);
        chk("wrap_chk", 32'(if0.check_count), 32'd10);
        chk("wrap_cnt", 32'(cnt), 32'h00);

        load = 1'b1; entrada = 8'h11;
        cyc();
        load = 1'b0;
        cyc();
        off = 8'hFE;
        cyc();
        chk("inj_mis0",  32'(if0.mismatch), 32'd1);
        chk("inj_fail0", 32'(if0.fail), 32'd1);
        chk("inj_exp0",  32'(if0.first_exp), 32'h12);
        chk("inj_obs0",  32'(if0.first_obs), 32'h10);
        chk("inj_err0",  32'(if0.error_count), 32'd1);
        chk("inj_mis1",  32'(if1.mismatch), 32'd1);
        chk("inj_err2",  32'(if2.error_count), 32'd1);

        cyc();
        chk("pulse_mis1", 32'(if1.mismatch), 32'd0);
        chk("rs_err1",    32'(if1.error_count), 32'd1);
        chk("fr_mis0",    32'(if0.mismatch), 32'd1);
        chk("fr_err0",    32'(if0.error_count), 32'd2);
        chk("keep_exp0",  32'(if0.first_exp), 32'h12);
        chk("keep_obs0",  32'(if0.first_obs), 32'h10);
        chk("rs_obs1",    32'(if1.first_obs), 32'h10);

        cyc();
        chk("halt_mis2",   32'(if2.mismatch), 32'd1);
        chk("halt_err2",   32'(if2.error_count), 32'd3);
        chk("halt_state2", 32'(if2.state), 32'd2);

        cyc();
        chk("hold_mis2",   32'(if2.mismatch), 32'd0);
        chk("hold_err2",   32'(if2.error_count), 32'd3);
        chk("hold_state2", 32'(if2.state), 32'd2);
        chk("hold_chk2",   32'(if2.check_count), 32'd3);
        chk("fr_err0b",    32'(if0.error_count), 32'd4);
        chk("rs_chk1",     32'(if1.check_count), 32'd16);
        chk("rs_err1b",    32'(if1.error_count), 32'd1);

        enable = 1'b0;
        cyc();
        chk("en0_mis0", 32'(if0.mismatch), 32'd0);
        chk("en0_err0", 32'(if0.error_count), 32'd4);
        chk("en0_chk0", 32'(if0.check_count), 32'd16);
        enable = 1'b1;
        cyc();
        chk("en1_mis0", 32'(if0.mismatch), 32'd1);
        chk("en1_err0", 32'(if0.error_count), 32'd5);
        chk("en1_chk1", 32'(if1.check_count), 32'd17);
        chk("en1_mis1", 32'(if1.mismatch), 32'd0);

        #1;
        reset = 1'b0;
        off   = 8'd0;
        #1;
        chk("arst_state", 32'(if0.state), 32'd0);
        chk("arst_fail",  32'(if0.fail), 32'd0);
        chk("arst_err",   32'(if0.error_count), 32'd0);
        chk("arst_chk",   32'(if0.check_count), 32'd0);
        chk("arst_exp",   32'(if0.first_exp), 32'd0);
        chk("arst_obs",   32'(if0.first_obs), 32'd0);
        chk("arst_mis",   32'(if0.mismatch), 32'd0);
        chk("arst_st2",   32'(if2.state), 32'd0);

        @(negedge clock);
        #1 reset = 1'b1;
        cyc();
        chk("re_state", 32'(if0.state), 32'd1);
        chk("re_nochk", 32'(if0.check_count), 32'd0);
        cyc();
        chk("re_chk",   32'(if0.check_count), 32'd1);
        chk("re_mis",   32'(if0.mismatch), 32'd0);
        chk("re_err",   32'(if0.error_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
